equalizer_dial_controller: RTL and testbench

Keyboard-driven control stage for the 12-band graphic equalizer. Decodes PS/2 Set-2 scan codes from the keyboard receiver, tracks the selected band, and holds one 5-bit dial value per band (0..24 = −12..+12 dB, 12 = flat). The dial outputs feed the VGA band display and the filter-coefficient updater; a one-cycle `update` pulse announces every change.

---
 rtl/equalizer_dial_controller.sv | 174 +++++++++++++++++
 tb/tb_equalizer_dial_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/equalizer_dial_controller.sv
// Keyboard control stage for the 12-band graphic equalizer: decodes PS/2 Set-2
// make codes into band select, dial up/down and flat-all actions.
module equalizer_dial_controller #(
   parameter int NUM_BANDS = 12,
   parameter int DIAL_MAX  = 24,
   parameter int DIAL_FLAT = 12
) (
   input  logic       clk50,
   input  logic       reset_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [4:0] dial31,
   output logic [4:0] dial72,
   output logic [4:0] dial150,
   output logic [4:0] dial250,
   output logic [4:0] dial440,
   output logic [4:0] dial630,
   output logic [4:0] dial1000,
   output logic [4:0] dial2500,
   output logic [4:0] dial5000,
   output logic [4:0] dial8000,
   output logic [4:0] dial14000,
   output logic [4:0] dial20000,
   output logic [3:0] sel_band,
   output logic       update,
   output logic [3:0] update_band
);

   // state   | meaning
   // IDLE    | waiting for the first byte of a sequence
   // EXT     | E0 prefix seen, next byte selects an arrow action
   // BRK     | F0 seen, next byte is a discarded break code
   // EXT_BRK | E0 F0 seen, next byte is a discarded extended break code
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   localparam logic [4:0] DMAX     = 5'(DIAL_MAX);
   localparam logic [4:0] DFLAT    = 5'(DIAL_FLAT);
   localparam logic [3:0] BAND_TOP = 4'(NUM_BANDS - 1);
   localparam logic [3:0] BAND_ALL = 4'hF;

   state_t     state_q, state_d;
   logic [4:0] dial_q [NUM_BANDS];
   logic [4:0] dial_d [NUM_BANDS];
   logic [3:0] sel_q, sel_d;
   logic       upd_q, upd_d;
   logic [3:0] updb_q, updb_d;

   logic act_left, act_right, act_up, act_down, act_flat;

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      act_left  = 1'b0;
      act_right = 1'b0;
      act_up    = 1'b0;
      act_down  = 1'b0;
      act_flat  = 1'b0;
      if (scan_valid) begin
         case (state_q)
            IDLE: begin
               if (scan_code == SC_EXT) begin
                  state_d = EXT;
               end else if (scan_code == SC_BRK) begin
                  state_d = BRK;
               end else if (scan_code == SC_ESC) begin
                  act_flat = 1'b1;
               end
            end
            EXT: begin
               state_d = IDLE;
               case (scan_code)
                  SC_BRK:   state_d   = EXT_BRK;
                  SC_LEFT:  act_left  = 1'b1;
                  SC_RIGHT: act_right = 1'b1;
                  SC_UP:    act_up    = 1'b1;
                  SC_DOWN:  act_down  = 1'b1;
                  default:  state_d   = IDLE;
               endcase
            end
            BRK:     state_d = IDLE;
            EXT_BRK: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Bounds are tested before stepping so the 5-bit dial never wraps.
   always_comb begin
      for (int i = 0; i < NUM_BANDS; i++) begin
         dial_d[i] = dial_q[i];
      end
      sel_d  = sel_q;
      upd_d  = 1'b0;
      updb_d = updb_q;
      if (act_flat) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            dial_d[i] = DFLAT;
         end
         upd_d  = 1'b1;
         updb_d = BAND_ALL;
      end else if (act_left) begin
         sel_d = (sel_q == 4'd0) ? BAND_TOP : sel_q - 4'd1;
      end else if (act_right) begin
         sel_d = (sel_q == BAND_TOP) ? 4'd0 : sel_q + 4'd1;
      end else if (act_up) begin
         if (dial_q[sel_q] < DMAX) begin
            dial_d[sel_q] = dial_q[sel_q] + 5'd1;
            upd_d         = 1'b1;
            updb_d        = sel_q;
         end
      end else if (act_down) begin
         if (dial_q[sel_q] > 5'd0) begin
            dial_d[sel_q] = dial_q[sel_q] - 5'd1;
            upd_d         = 1'b1;
            updb_d        = sel_q;
         end
      end
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            dial_q[i] <= DFLAT;
         end
         sel_q  <= 4'd0;
         upd_q  <= 1'b0;
         updb_q <= 4'd0;
      end else begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            dial_q[i] <= dial_d[i];
         end
         sel_q  <= sel_d;
         upd_q  <= upd_d;
         updb_q <= updb_d;
      end
   end

   assign dial31      = dial_q[0];
   assign dial72      = dial_q[1];
   assign dial150     = dial_q[2];
   assign dial250     = dial_q[3];
   assign dial440     = dial_q[4];
   assign dial630     = dial_q[5];
   assign dial1000    = dial_q[6];
   assign dial2500    = dial_q[7];
   assign dial5000    = dial_q[8];
   assign dial8000    = dial_q[9];
   assign dial14000   = dial_q[10];
   assign dial20000   = dial_q[11];
   assign sel_band    = sel_q;
   assign update      = upd_q;
   assign update_band = updb_q;

endmodule

// File: tb/tb_equalizer_dial_controller.sv
// Bench for equalizer_dial_controller: directed key sequences plus a random byte
// stream, checked every cycle against a prefix-queue model of the keyboard rules.
module tb_equalizer_dial_controller;

   logic       clk50 = 1'b0;
   logic       reset_n;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic [4:0] dial31, dial72, dial150, dial250, dial440, dial630;
   logic [4:0] dial1000, dial2500, dial5000, dial8000, dial14000, dial20000;
   logic [3:0] sel_band;
   logic       update;
   logic [3:0] update_band;

   always #10 clk50 = ~clk50;

   equalizer_dial_controller dut (
      .clk50(clk50), .reset_n(reset_n), .scan_code(scan_code), .scan_valid(scan_valid),
      .dial31(dial31), .dial72(dial72), .dial150(dial150), .dial250(dial250),
      .dial440(dial440), .dial630(dial630), .dial1000(dial1000), .dial2500(dial2500),
      .dial5000(dial5000), .dial8000(dial8000), .dial14000(dial14000), .dial20000(dial20000),
      .sel_band(sel_band), .update(update), .update_band(update_band)
   );

   logic [4:0] d_out [12];
   assign d_out[0]  = dial31;    assign d_out[1]  = dial72;
   assign d_out[2]  = dial150;   assign d_out[3]  = dial250;
   assign d_out[4]  = dial440;   assign d_out[5]  = dial630;
   assign d_out[6]  = dial1000;  assign d_out[7]  = dial2500;
   assign d_out[8]  = dial5000;  assign d_out[9]  = dial8000;
   assign d_out[10] = dial14000; assign d_out[11] = dial20000;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   bit run_chk = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bytes since the last idle point are kept in a queue.
   int             m_dial [12];
   int             m_sel;
   bit             m_upd;
   int             m_updb;
   byte unsigned   pfx [$];

   task automatic model_step(input byte unsigned b);
      if (pfx.size() == 0) begin
         if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
         else if (b == 8'h76) begin
            for (int i = 0; i < 12; i++) m_dial[i] = 12;
            m_upd = 1; m_updb = 15;
         end
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
         if (b == 8'hF0) pfx.push_back(b);
         else begin
            pfx.delete();
            case (b)
               8'h6B: m_sel = (m_sel + 11) % 12;
               8'h74: m_sel = (m_sel + 1) % 12;
               8'h75: if (m_dial[m_sel] < 24) begin m_dial[m_sel]++; m_upd = 1; m_updb = m_sel; end
               8'h72: if (m_dial[m_sel] > 0)  begin m_dial[m_sel]--; m_upd = 1; m_updb = m_sel; end
               default: ;
            endcase
         end
      end else begin
         pfx.delete();
      end
   endtask

   always @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 12; i++) m_dial[i] = 12;
         m_sel = 0; m_upd = 0; m_updb = 0;
         pfx.delete();
      end else begin
         m_upd = 0;
         if (scan_valid) model_step(scan_code);
      end
   end

   always @(posedge clk50) begin
      #1;
      if (run_chk) begin
         for (int i = 0; i < 12; i++) chk($sformatf("dial[%0d]", i), d_out[i], m_dial[i]);
         chk("sel_band", sel_band, m_sel);
         chk("update", update, m_upd);
         if (m_upd) chk("update_band", update_band, m_updb);
         if (update) pulses++;
      end
   end

   task automatic send(input byte unsigned b);
      @(negedge clk50);
      scan_code  = b;
      scan_valid = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk50);
         scan_valid = 1'b0;
         scan_code  = 8'($urandom);
      end
   endtask

   task automatic key(input byte unsigned b);
      send(8'hE0); send(b); gap(1);
   endtask

   byte unsigned codes [12] = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'h76, 8'h75,
                                8'h72, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h12};
   int p0;

   initial begin
      reset_n = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
      run_chk = 1'b1;
      gap(3);
      chk("rst dial31", dial31, 12);
      chk("rst sel", sel_band, 0);
      chk("rst update", update, 0);
      chk("rst update_band", update_band, 0);
      reset_n = 1'b1;
      gap(1);

      p0 = pulses;
      repeat (3) key(8'h75);
      chk("up3 dial31", dial31, 15);
      chk("up3 pulses", pulses - p0, 3);
      chk("up3 dial72", dial72, 12);

      key(8'h6B);
      chk("left wrap sel", sel_band, 11);
      p0 = pulses;
      repeat (14) key(8'h72);
      chk("down dial20000", dial20000, 0);
      chk("down pulses", pulses - p0, 12);

      key(8'h74);
      chk("right wrap sel", sel_band, 0);
      for (int i = 0; i < 12; i++) begin
         key(8'h74);
         send(8'hE0); send(8'hF0); send(8'h74); gap(1);
         if (i == 4) chk("right5 sel", sel_band, 5);
      end
      chk("right12 sel", sel_band, 0);

      repeat (6) key(8'h74);
      repeat (14) key(8'h75);
      chk("sat dial1000", dial1000, 24);
      send(8'h76);
      gap(1);
      chk("esc update", update, 1);
      chk("esc update_band", update_band, 15);
      gap(1);
      chk("esc pulse width", update, 0);
      chk("esc dial1000", dial1000, 12);
      chk("esc dial31", dial31, 12);
      chk("esc sel kept", sel_band, 6);

      send(8'hE0); send(8'h12); send(8'hF0); send(8'h75); send(8'h75);
      send(8'hE0); send(8'h75); send(8'hE0); send(8'h75); gap(2);
      chk("mix dial1000", dial1000, 14);

      send(8'hE0); gap(1);
      reset_n = 1'b0; gap(2);
      chk("midrst dial1000", dial1000, 12);
      reset_n = 1'b1;
      p0 = pulses;
      send(8'h75); gap(2);
      chk("midrst pulses", pulses - p0, 0);
      chk("midrst dial31", dial31, 12);
      chk("midrst sel", sel_band, 0);
      key(8'h75);
      chk("post rst up", dial31, 13);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            @(negedge clk50); reset_n = 1'b0; scan_valid = 1'b0;
            @(negedge clk50); reset_n = 1'b1;
         end
         if ($urandom_range(0, 11) == 0) send(8'($urandom));
         else send(codes[$urandom_range(0, 11)]);
         gap($urandom_range(0, 2));
      end
      gap(2);
      run_chk = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
